iob_sp_ram_be_ctrl: RTL and testbench
=====================================

// Module: iob_sp_ram_be_ctrl
// PURPOSE
//  Request/response front-end placed directly upstream of the byte-enable single-port RAM.
//  - Accepts valid/ready requests and drives the RAM en/we/addr/din pins.
//  - Captures RAM dout one cycle after each read and buffers it in a response FIFO.
//  - Read data is returned to the requester under rsp_valid/rsp_ready backpressure.
//  - Writes are posted and produce no response.
// PARAMETERS
//  NUM_COL     4                   byte lanes per word
//  COL_WIDTH   8                   bits per lane
//  ADDR_WIDTH  10                  word address width; RAM depth = 2**ADDR_WIDTH
//  DATA_WIDTH  NUM_COL*COL_WIDTH   word width
//  RSP_DEPTH   3                   response FIFO entries; must be >=2; 3 sustains 1 read/cycle
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous reset, active-high
//  req_valid  in   1           request present
//  req_ready  out  1           request accepted when req_valid & req_ready at clk edge
//  req_addr   in   ADDR_WIDTH  word address
//  req_wdata  in   DATA_WIDTH  write data
//  req_wstrb  in   NUM_COL     byte strobes; all-zero = read, non-zero = write
//  rsp_valid  out  1           read data available
//  rsp_ready  in   1           consumer takes rsp_rdata when rsp_valid & rsp_ready
//  rsp_rdata  out  DATA_WIDTH  read data, returned in request order
//  ram_en     out  1           RAM enable
//  ram_we     out  NUM_COL     RAM byte write enables
//  ram_addr   out  ADDR_WIDTH  RAM address
//  ram_din    out  DATA_WIDTH  RAM write data
//  ram_dout   in   DATA_WIDTH  RAM read data; registered, valid the cycle after an enabled read
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - count, rd_ptr, wr_ptr, inflight all 0.
//    - rsp_valid=0; req_ready=0 and ram_en=0 while rst is high.
//  - Credit rule: req_ready = !rst & ((count + inflight) < RSP_DEPTH).
//    - Registered state only; no combinational path from req_valid or rsp_ready.
//    - Applies to reads and writes alike, which keeps ordering trivial.
//  - Issue (combinational):
//    - ram_en   = req_valid & req_ready
//    - ram_we   = req_wstrb when ram_en, else 0
//    - ram_addr = req_addr
//    - ram_din  = req_wdata
//  - Read (wstrb==0) accepted at edge E0:
//    - inflight<=1; RAM presents data in cycle E0..E1.
//    - At E1 ram_dout is pushed into the FIFO.
//    - inflight<=1 again if another read is accepted at E1, else 0.
//    - rsp_valid rises after E1: 2-cycle accept-to-response latency.
//  - Write (wstrb!=0): single-cycle RAM write, inflight unchanged.
//    - The old word the RAM returns on dout (read-first) is discarded.
//  - FIFO:
//    - rsp_valid = (count!=0); rsp_rdata = mem[rd_ptr].
//    - Pop on rsp_valid & rsp_ready.
//    - Pointers wrap modulo RSP_DEPTH (non-power-of-2 supported).
//    - Simultaneous push+pop: count unchanged, both pointers advance.
//    - Push into a full FIFO is impossible by the credit rule; verification asserts this.
//  - Throughput:
//    - Back-to-back reads with rsp_ready=1 run at 1/cycle (steady state count=1, inflight=1).
//    - rsp_ready=0 stalls req_ready once count+inflight reaches RSP_DEPTH.
//  - Reset mid-operation:
//    - Buffered and in-flight read data are dropped; no response after reset.
//    - A RAM write already clocked completes; none is issued while rst is high.
// STRUCTURE
//  - Shared header: strobe-is-read test (~|wstrb) and the RSP_DEPTH>=2 check, as localparams/macros.
//  - One sub-module, iob_sync_fifo: DATA_WIDTH x RSP_DEPTH, push/pop/count, async active-high rst.
//  - Top holds the credit logic, the inflight flop and RAM pin muxing.
//  - Bench instantiates the block together with the byte-enable RAM.
// TESTING
//  1. Reset: assert rst mid-cycle -> rsp_valid=0, req_ready=0, ram_en=0 immediately. Release -> req_ready=1.
//  2. Write 0xDEADBEEF @0x005, wstrb=4'hF; then read @0x005 -> rsp_rdata=0xDEADBEEF 2 cycles after accept. No response for the write.
//  3. Byte lanes: write 0x000000AA with wstrb=4'h1 over 0x11223344 @0x3FF -> read returns 0x112233AA.
//  4. Backpressure: rsp_ready=0, issue 5 reads @0..4 -> exactly 3 accepted, then req_ready=0. Release rsp_ready -> data in order, then remaining 2 reads accepted.
//  5. Streaming: 16 consecutive reads with rsp_ready=1 -> req_ready stays 1, one response per cycle, count never >1.
//  6. Reset with 2 buffered + 1 in-flight read -> after release no rsp_valid. Next read returns correct data.

Source files
------------

// File: rtl/iob_sp_ram_be_ctrl_pkg.sv
// Shared definitions for the byte-enable RAM request/response front-end.
// Holds the strobe-is-read test and the minimum response buffer depth.
package iob_sp_ram_be_ctrl_pkg;

    localparam int unsigned MIN_RSP_DEPTH = 2;
    localparam int unsigned MAX_NUM_COL   = 64;

    // An all-zero strobe is a read; callers zero-extend their strobe to MAX_NUM_COL.
    function automatic logic strb_is_read(input logic [MAX_NUM_COL-1:0] wstrb);
        return ~|wstrb;
    endfunction

endpackage

// File: rtl/iob_sp_ram_be_ctrl_if.sv
// Request/response bus between a requester (master) and the RAM front-end (slave).
interface iob_sp_ram_be_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_COL    = 4
);

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [NUM_COL-1:0]    req_wstrb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/iob_sync_fifo.sv
// Synchronous FIFO with arbitrary (non-power-of-2) depth and an occupancy count.
module iob_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The upstream credit scheme must never let a push land on a full buffer.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/iob_sp_ram_be_ctrl.sv
// Valid/ready front-end for a byte-enable single-port RAM: issues requests,
// captures read data one cycle later and returns it through a credit-limited FIFO.
module iob_sp_ram_be_ctrl
    import iob_sp_ram_be_ctrl_pkg::*;
#(
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH,
    parameter int unsigned RSP_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    iob_sp_ram_be_ctrl_if.slave   bus,
    output logic                  ram_en,
    output logic [NUM_COL-1:0]    ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    if (RSP_DEPTH < MIN_RSP_DEPTH) begin : g_bad_depth
        $error("iob_sp_ram_be_ctrl: RSP_DEPTH must be at least %0d", MIN_RSP_DEPTH);
    end

    logic             inflight;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   outstanding;
    logic             accept;
    logic             rd_accept;
    logic             pop;

    // Every read either sits in the FIFO or is in flight, so their sum is the credit in use.
    assign outstanding   = {1'b0, count} + (CNT_W + 1)'(inflight);
    assign bus.req_ready = !rst && (outstanding < (CNT_W + 1)'(RSP_DEPTH));

    assign accept    = bus.req_valid && bus.req_ready;
    assign rd_accept = accept && strb_is_read(MAX_NUM_COL'(bus.req_wstrb));

    assign ram_en   = accept;
    assign ram_we   = accept ? bus.req_wstrb : '0;
    assign ram_addr = bus.req_addr;
    assign ram_din  = bus.req_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_accept;
        end
    end

    assign bus.rsp_valid = (count != '0);
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    iob_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (ram_dout),
        .pop       (pop),
        .pop_data  (bus.rsp_rdata),
        .count     (count)
    );

endmodule

// File: tb/tb_iob_sp_ram_be_ctrl.sv
// Randomised and directed bench for iob_sp_ram_be_ctrl with a behavioural byte-enable RAM.
module tb_iob_sp_ram_be_ctrl;

    localparam int unsigned NUM_COL    = 4;
    localparam int unsigned COL_WIDTH  = 8;
    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned RSP_DEPTH  = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  ram_en;
    logic [NUM_COL-1:0]    ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout = '0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    iob_sp_ram_be_ctrl_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_COL    (NUM_COL)
    ) bus ();

    iob_sp_ram_be_ctrl #(
        .NUM_COL    (NUM_COL),
        .COL_WIDTH  (COL_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // Read-first byte-enable RAM with registered output.
    logic [DATA_WIDTH-1:0] ram_mem [1 << ADDR_WIDTH];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout <= ram_mem[ram_addr];
            for (int i = 0; i < NUM_COL; i++) begin
                if (ram_we[i]) ram_mem[ram_addr][i*COL_WIDTH +: COL_WIDTH] <= ram_din[i*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    // Reference model: memory image plus a queue of reads not yet consumed.
    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        int unsigned           tag;
    } exp_t;

    logic [DATA_WIDTH-1:0] ref_mem [1 << ADDR_WIDTH];
    exp_t                  exp_q [$];
    int unsigned           edge_n = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, check, advance the model at the rising edge.
    task automatic step(input logic r, input logic v, input logic [ADDR_WIDTH-1:0] a,
                        input logic [DATA_WIDTH-1:0] d, input logic [NUM_COL-1:0] s,
                        input logic rr, output logic acc);
        logic exp_ready;
        logic exp_valid;
        rst           = r;
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        bus.rsp_ready = rr;
        #1;
        exp_ready = !r && (exp_q.size() < RSP_DEPTH);
        exp_valid = !r && (exp_q.size() > 0) && (exp_q[0].tag < edge_n);
        acc       = v && exp_ready;
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
        if (exp_valid) check("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_q[0].data));
        check("ram_en", 64'(ram_en), 64'(acc));
        check("ram_we", 64'(ram_we), acc ? 64'(s) : 64'd0);
        if (acc) begin
            check("ram_addr", 64'(ram_addr), 64'(a));
            check("ram_din", 64'(ram_din), 64'(d));
        end
        @(posedge clk);
        edge_n++;
        if (r) begin
            exp_q.delete();
        end else begin
            if (exp_valid && rr) void'(exp_q.pop_front());
            if (acc) begin
                if (s == '0) begin
                    exp_q.push_back('{data: ref_mem[a], tag: edge_n});
                end else begin
                    for (int i = 0; i < NUM_COL; i++)
                        if (s[i]) ref_mem[a][i*COL_WIDTH +: COL_WIDTH] = d[i*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rr);
        logic acc;
        step(1'b0, 1'b0, '0, '0, '0, rr, acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1'b1);
        check("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic        acc;
        int unsigned n_acc;

        for (int i = 0; i < (1 << ADDR_WIDTH); i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);

        // Reset held with a pending request: nothing may be issued.
        step(1'b1, 1'b1, 10'h001, 32'h1, 4'hF, 1'b1, acc);
        step(1'b1, 1'b1, 10'h001, 32'h1, 4'hF, 1'b1, acc);
        idle(1'b1);
        check("rst_release_ready", 64'(bus.req_ready), 64'd1);

        // Full-word write then read back; the write produces no response.
        step(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 1'b1, acc);
        step(1'b0, 1'b1, 10'h005, 32'h0, 4'h0, 1'b0, acc);
        idle(1'b0);
        check("rd_5_valid", 64'(bus.rsp_valid), 64'd1);
        check("rd_5_data", 64'(bus.rsp_rdata), 64'hDEADBEEF);
        idle(1'b1);

        // Single byte lane over an existing word at the top address.
        step(1'b0, 1'b1, 10'h3FF, 32'h11223344, 4'hF, 1'b1, acc);
        step(1'b0, 1'b1, 10'h3FF, 32'h000000AA, 4'h1, 1'b1, acc);
        step(1'b0, 1'b1, 10'h3FF, 32'h0, 4'h0, 1'b0, acc);
        idle(1'b0);
        check("lane_data", 64'(bus.rsp_rdata), 64'h112233AA);
        idle(1'b1);

        // Backpressure: only RSP_DEPTH reads fit while responses are held.
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 10'(i), 32'h0A0B0C00 + 32'(i), 4'hF, 1'b1, acc);
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 10'(n_acc), '0, '0, 1'b0, acc);
            if (acc) n_acc++;
        end
        check("bp_accepted", 64'(n_acc), 64'd3);
        check("bp_ready_low", 64'(bus.req_ready), 64'd0);
        for (int i = 0; i < 20 && (n_acc < 5 || exp_q.size() > 0); i++) begin
            step(1'b0, n_acc < 5, 10'(n_acc), '0, '0, 1'b1, acc);
            if (acc) n_acc++;
        end
        check("bp_all_accepted", 64'(n_acc), 64'd5);
        drain();

        // Streaming reads at one per cycle.
        n_acc = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 10'(i), '0, '0, 1'b1, acc);
            if (acc) n_acc++;
        end
        check("stream_accepted", 64'(n_acc), 64'd16);
        drain();

        // Randomised traffic over a small address window.
        for (int i = 0; i < 400; i++) begin
            logic [NUM_COL-1:0] s;
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            step(1'b0, 1'($urandom_range(0, 3) != 0), 10'($urandom_range(0, 15)),
                 32'($urandom()), s, 1'($urandom_range(0, 2) != 0), acc);
        end
        drain();

        // Reset with two buffered reads and one in flight.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 10'h005, '0, '0, 1'b0, acc);
        step(1'b1, 1'b1, 10'h005, '0, '0, 1'b1, acc);
        step(1'b1, 1'b0, 10'h005, '0, '0, 1'b1, acc);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("post_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
        step(1'b0, 1'b1, 10'h3FF, '0, '0, 1'b0, acc);
        idle(1'b0);
        check("post_rst_valid", 64'(bus.rsp_valid), 64'd1);
        check("post_rst_data", 64'(bus.rsp_rdata), 64'(ref_mem[10'h3FF]));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
